alu_ctrl: RTL
=============

Name: alu_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the 4-bit `alu`.
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from a 4-entry register file.
- Drives the ALU's A, B, Op and L inputs from registers, then captures the ALU's R, Z, C and S outputs into the destination register and a flag register.
- Provides a minimal execute/writeback loop so the ALU can be exercised by programs rather than forced stimulus.

Parameters:
- WIDTH, 4, datapath width. Must match the ALU. Only 4 is verified.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on `instr`.
- in_ready  out  1  controller can accept an instruction.
- instr  in  12  instruction word (fields below).
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  high together with `done` when the retired instruction was class 11.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_op  out  2  ALU Op.
- alu_l  out  1  ALU L select (1 = logic, 0 = arithmetic).
- alu_r  in  WIDTH  ALU result.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry flag.
- alu_s  in  1  ALU sign flag.
- flag_z  out  1  registered zero flag.
- flag_c  out  1  registered carry flag.
- flag_s  out  1  registered sign flag.
- rd_sel  in  2  debug read-port register select.
- rd_data  out  WIDTH  debug read data; combinational read of reg[rd_sel].

Behaviour:
- Instruction fields:
  - [11:10] class: 00 ALU, 01 LOADI, 10 CMP, 11 reserved.
  - [9] L, [8:7] Op, [6:5] rd, [4:3] ra, [2:1] rb, [0] ignored.
  - LOADI takes its immediate from [3:0]. For LOADI, [9:7] are ignored.
- Reset (synchronous): reg[0..3]=0, flag_z/c/s=0, alu_a/alu_b/alu_op/alu_l=0, done=0, illegal=0, state=IDLE. Reset wins over any simultaneous handshake and aborts an instruction in flight with no writeback and no done.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch instr and go to EXEC. Also load alu_a=reg[ra], alu_b=reg[rb], alu_op=Op, alu_l=L (class 00/10 only; other classes leave the ALU outputs unchanged).
  - EXEC: in_ready=0. The ALU settles combinationally from the registered operands. At the end of the cycle, writeback is done per class (see below). Go to DONE.
  - DONE: in_ready=0, done=1, illegal=(class==11). Go to IDLE.
- Writeback at the EXEC edge:
  - ALU: reg[rd]=alu_r and flag_z=alu_z. If L=0, flag_c=alu_c and flag_s=alu_s. If L=1, flag_c and flag_s hold, because the ALU carry/sign are don't-care for logic ops.
  - CMP: same flag updates as ALU, no register write.
  - LOADI: reg[rd]=imm and flag_z=(imm==0). flag_c and flag_s hold.
  - Reserved: no register or flag change.
- Latency and throughput:
  - Accept at edge N; writeback visible at edge N+1; done high during cycle N+2.
  - Throughput is one instruction per 3 cycles. in_ready is 0 for exactly 2 cycles after each accept.
  - in_valid asserted while in_ready=0 is ignored; the instruction is not queued.
- Operands: ra==rb is legal. rd may equal ra or rb; operands are sampled at accept, so the old value is used.
- Register contents are never modified outside writeback. rd_data reflects the write from the cycle after the EXEC edge.
- Arithmetic wraps modulo 2^WIDTH; the carry out comes only from the ALU.
- alu_* outputs hold their last value between instructions. They are not cleared on DONE.

Test Plan:
- After reset, with no instruction: in_ready=1, done=0, all flags 0, rd_data=0 for every rd_sel.
- LOADI r1,0101 then LOADI r2,0011 → each done pulses 2 cycles after accept; reg1=0101, reg2=0011; flag_z=0.
- ALU L=0 Op=10 rd=3 ra=1 rb=2 → alu_a=0101, alu_b=0011; reg3=1000, flag_c=0, flag_s=1, flag_z=0.
- ALU L=0 Op=11 rd=0 ra=2 rb=2 → reg0=0000, flag_z=1, flag_c=1, flag_s=0. Follow with ALU L=1 Op=00 rd=3 ra=1 rb=2 → reg3=0001, flag_z=0, flag_c=1 and flag_s=0 held.
- CMP L=0 Op=11 ra=2 rb=1 → no register changes, flag_s=1, flag_c=0. Reserved class → done=1, illegal=1, registers and flags unchanged.
- Handshake and reset:
  - Hold in_valid high continuously → exactly one accept per 3 cycles.
  - Assert reset during EXEC → no writeback, no done pulse, all state returns to reset values on the next edge.

Source files
------------

// File: rtl/alu_ctrl.sv
// Execute/writeback sequencer for the 4-bit alu: accepts one instruction at a time,
// drives registered ALU operands and captures the result into a 4-entry register file.
module alu_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      instr,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_l,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_s,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_s,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned NREG  = 4;
  localparam int unsigned IMM_W = 4;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LDI  = 2'b01;
  localparam logic [1:0] CLS_CMP  = 2'b10;
  localparam logic [1:0] CLS_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_regs [NREG];
  logic [1:0]         r_class;
  logic [1:0]         r_rd;
  logic [IMM_W-1:0]   r_imm;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [1:0]         r_alu_op;
  logic               r_alu_l;
  logic               r_flag_z;
  logic               r_flag_c;
  logic               r_flag_s;
  logic               w_in_ready;
  logic               w_done;
  logic               w_illegal;
  logic               w_accept;
  logic [1:0]         w_in_class;
  logic [WIDTH-1:0]   w_imm;

  assign w_accept   = in_valid & w_in_ready;
  assign w_in_class = instr[11:10];
  assign w_imm      = WIDTH'(r_imm);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake and retire outputs decoded from the state register
  always_comb begin
    w_in_ready = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_DONE: begin
        w_done    = 1'b1;
        w_illegal = (r_class == CLS_RSVD);
      end
      default: ;
    endcase
  end

  // Instruction latch, operand drive and writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_class  <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_alu_l  <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_s <= 1'b0;
    end else begin
      if (w_accept) begin
        r_class <= w_in_class;
        r_rd    <= instr[6:5];
        r_imm   <= instr[3:0];
        // Only ALU and CMP touch the ALU inputs; operands use pre-writeback values
        if (w_in_class == CLS_ALU || w_in_class == CLS_CMP) begin
          r_alu_a  <= r_regs[instr[4:3]];
          r_alu_b  <= r_regs[instr[2:1]];
          r_alu_op <= instr[8:7];
          r_alu_l  <= instr[9];
        end
      end
      if (r_state == S_EXEC) begin
        case (r_class)
          CLS_ALU, CLS_CMP: begin
            if (r_class == CLS_ALU) r_regs[r_rd] <= alu_r;
            r_flag_z <= alu_z;
            // Carry/sign from a logic op are meaningless, so keep the old ones
            if (!r_alu_l) begin
              r_flag_c <= alu_c;
              r_flag_s <= alu_s;
            end
          end
          CLS_LDI: begin
            r_regs[r_rd] <= w_imm;
            r_flag_z     <= (w_imm == '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready = w_in_ready;
  assign done     = w_done;
  assign illegal  = w_illegal;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign alu_l    = r_alu_l;
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;
  assign flag_s   = r_flag_s;
  assign rd_data  = r_regs[rd_sel];

endmodule
